// File: rtl/boid_frame_scheduler.sv
// Boid frame scheduler: walks every self boid i over the shared single-port boid
// memory, latching i, streaming each neighbour j != i to the pairwise accelerator,
// triggering the update step and writing boid i back. Stalls whenever the memory
// initializer owns the memory.
module boid_frame_scheduler #(
    parameter int unsigned  NumBoids = 2,
    parameter logic [6:0]   WbMask   = 7'h7F,
    localparam int unsigned Iw       = $clog2(NumBoids)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          frame_start_i,
    input  logic          mem_busy_i,
    output logic [Iw-1:0] which_boid_o,
    output logic [6:0]    wb_en_o,
    output logic          self_latch_o,
    output logic          pair_valid_o,
    input  logic          pair_ready_i,
    output logic          upd_start_o,
    input  logic          upd_done_i,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          overrun_o
);

    localparam int unsigned Cw      = Iw + 1;
    // Counters carry one spare bit so the terminal compare never aliases.
    localparam logic [Iw:0] LastIdx = Cw'(NumBoids - 1);
    localparam logic [Iw:0] IdxOne  = Cw'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPair,
        StUpdStart,
        StUpdWait,
        StWb,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [Iw:0] i_q, i_d;
    logic [Iw:0] j_q, j_d;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic        go;
    logic        advance;

    // State, boid counters and request flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            i_q       <= '0;
            j_q       <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic and per-state memory/accelerator strobes.
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q | (frame_start_i & (state_q != StIdle));
        which_boid_o = i_q[Iw-1:0];
        wb_en_o      = '0;
        self_latch_o = 1'b0;
        pair_valid_o = 1'b0;
        upd_start_o  = 1'b0;
        frame_done_o = 1'b0;
        advance      = 1'b0;
        // A request arriving in the departure cycle is the one that starts the frame.
        go           = pending_q | frame_start_i;

        unique case (state_q)
            StIdle: begin
                if (frame_start_i) begin
                    pending_d = 1'b1;
                end
                if (go && !mem_busy_i) begin
                    pending_d = 1'b0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                if (!mem_busy_i) begin
                    self_latch_o = 1'b1;
                    j_d          = '0;
                    state_d      = StPair;
                end
            end
            StPair: begin
                which_boid_o = j_q[Iw-1:0];
                if (!mem_busy_i) begin
                    if (j_q == i_q) begin
                        advance = 1'b1;
                    end else begin
                        pair_valid_o = 1'b1;
                        advance      = pair_ready_i;
                    end
                    if (advance) begin
                        if (j_q == LastIdx) begin
                            state_d = StUpdStart;
                        end else begin
                            j_d = j_q + IdxOne;
                        end
                    end
                end
            end
            StUpdStart: begin
                if (!mem_busy_i) begin
                    upd_start_o = 1'b1;
                    state_d     = StUpdWait;
                end
            end
            StUpdWait: begin
                if (!mem_busy_i && upd_done_i) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                if (!mem_busy_i) begin
                    wb_en_o = WbMask;
                    if (i_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        i_d     = i_q + IdxOne;
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                if (!mem_busy_i) begin
                    frame_done_o = 1'b1;
                    i_d          = '0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_o    = (state_q != StIdle);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Scoreboard bench for boid_frame_scheduler: a 4-boid instance for timing, stall,
// memory-busy, overrun, reset and random traffic, plus a 3-boid instance.
module tb_boid_frame_scheduler;

    typedef struct {
        int kind;  // 0 load, 1 pair transfer, 2 update start, 3 writeback, 4 frame done
        int a;
        int b;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       fs_a, mb_a, pr_a, ud_a;
    logic [1:0] wh_a;
    logic [6:0] wb_a;
    logic       sl_a, pv_a, us_a, busy_a, fd_a, ov_a;
    logic       fs_b, mb_b, pr_b, ud_b;
    logic [1:0] wh_b;
    logic [6:0] wb_b;
    logic       sl_b, pv_b, us_b, busy_b, fd_b, ov_b;

    boid_frame_scheduler #(.NumBoids(4), .WbMask(7'h7F)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs_a), .mem_busy_i(mb_a),
        .which_boid_o(wh_a), .wb_en_o(wb_a), .self_latch_o(sl_a), .pair_valid_o(pv_a),
        .pair_ready_i(pr_a), .upd_start_o(us_a), .upd_done_i(ud_a), .busy_o(busy_a),
        .frame_done_o(fd_a), .overrun_o(ov_a)
    );

    boid_frame_scheduler #(.NumBoids(3), .WbMask(7'h7F)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs_b), .mem_busy_i(mb_b),
        .which_boid_o(wh_b), .wb_en_o(wb_b), .self_latch_o(sl_b), .pair_valid_o(pv_b),
        .pair_ready_i(pr_b), .upd_start_o(us_b), .upd_done_i(ud_b), .busy_o(busy_b),
        .frame_done_o(fd_b), .overrun_o(ov_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    ev_t qa[$];
    ev_t qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic put(input int sel, input int k, input int a, input int b);
        ev_t e;
        e.kind = k; e.a = a; e.b = b;
        if (sel == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    // Reference model: the ordered list of observable events for one frame of n boids.
    task automatic push_frame(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            put(sel, 0, i, 0);
            for (int j = 0; j < n; j++) if (j != i) put(sel, 1, i, j);
            put(sel, 2, i, 0);
            put(sel, 3, i, 0);
        end
        put(sel, 4, 0, 0);
    endtask

    task automatic observe(input int sel, input int k, input int a, input int b);
        ev_t e;
        if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
            check($sformatf("unexpected_event_dut%0d", sel), k, -1);
        end else begin
            if (sel == 0) e = qa.pop_front();
            else e = qb.pop_front();
            check($sformatf("event_kind_dut%0d", sel), k, e.kind);
            check($sformatf("event_idx_a_dut%0d_kind%0d", sel, e.kind), a, e.a);
            check($sformatf("event_idx_b_dut%0d_kind%0d", sel, e.kind), b, e.b);
        end
    endtask

    // Accelerator stand-in: pair_ready policy and upd_done k cycles after upd_start.
    int  k_a = 3, k_b = 2, cd_a = 0, cd_b = 0, stall_left = 0, ready_mode = 0;
    bit  dp_a = 0, dp_b = 0;
    initial begin
        pr_a = 1'b1; ud_a = 1'b0; pr_b = 1'b1; ud_b = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                cd_a = 0; dp_a = 0; ud_a = 1'b0; cd_b = 0; dp_b = 0; ud_b = 1'b0;
            end else begin
                if (pv_a && stall_left > 0) begin
                    pr_a = 1'b0;
                    stall_left--;
                end else if (ready_mode == 1) pr_a = ($urandom_range(0, 2) != 0);
                else pr_a = 1'b1;
                if (cd_a > 0) begin cd_a--; if (cd_a == 0) dp_a = 1; end
                ud_a = dp_a;
                if (dp_a && !mb_a) dp_a = 0;
                if (us_a) cd_a = k_a;
                if (cd_b > 0) begin cd_b--; if (cd_b == 0) dp_b = 1; end
                ud_b = dp_b;
                if (dp_b && !mb_b) dp_b = 0;
                if (us_b) cd_b = k_b;
            end
        end
    end

    // Monitor: turns DUT strobes into events and checks them against the scoreboard.
    int cur_i_a = 0, xfer_a = 0, selfpair_a = 0, wb_cnt_a = 0, done_cnt_a = 0;
    int done_cyc_a = 0, load0_cyc_a = 0, run_a = 0, first_hold_a = 0, prev_wh = 0;
    int cur_i_b = 0, wb_cnt_b = 0, done_cnt_b = 0, done_cyc_b = 0;
    bit prev_stall = 0, prev_pv = 0;
    int wb_cycs_a[$];
    initial begin
        forever begin
            @(negedge clk); #2;
            if (prev_stall && !mb_a && rst_n) begin
                check("stall_valid_held", int'(pv_a), 1);
                check("stall_which_held", int'(wh_a), prev_wh);
            end
            if (mb_a && busy_a) begin
                check("membusy_no_strobes", int'({sl_a, pv_a, us_a, fd_a}), 0);
                check("membusy_no_wb_en", int'(wb_a), 0);
            end
            if (pv_a) run_a = (prev_pv && int'(wh_a) == prev_wh) ? run_a + 1 : 1;
            else run_a = 0;
            prev_stall = pv_a && !pr_a;
            prev_pv    = pv_a;
            prev_wh    = int'(wh_a);
            if (sl_a) begin
                cur_i_a = int'(wh_a);
                if (wh_a == 2'd0) load0_cyc_a = cyc;
                observe(0, 0, int'(wh_a), 0);
            end
            if (pv_a && pr_a) begin
                xfer_a++;
                if (int'(wh_a) == cur_i_a) selfpair_a++;
                if (cur_i_a == 0 && wh_a == 2'd1) first_hold_a = run_a;
                observe(0, 1, cur_i_a, int'(wh_a));
            end
            if (us_a) observe(0, 2, int'(wh_a), 0);
            if (wb_a != 7'd0) begin
                check("wb_en_value", int'(wb_a), 'h7F);
                wb_cnt_a++;
                wb_cycs_a.push_back(cyc);
                observe(0, 3, int'(wh_a), 0);
            end
            if (fd_a) begin
                done_cnt_a++;
                done_cyc_a = cyc;
                observe(0, 4, 0, 0);
            end
            if (busy_b) check("b_which_below_3", int'(wh_b < 2'd3), 1);
            if (sl_b) begin cur_i_b = int'(wh_b); observe(1, 0, int'(wh_b), 0); end
            if (pv_b && pr_b) observe(1, 1, cur_i_b, int'(wh_b));
            if (us_b) observe(1, 2, int'(wh_b), 0);
            if (wb_b != 7'd0) begin wb_cnt_b++; observe(1, 3, int'(wh_b), 0); end
            if (fd_b) begin done_cnt_b++; done_cyc_b = cyc; observe(1, 4, 0, 0); end
        end
    end

    int start_cyc = 0;

    task automatic pulse_a();
        @(negedge clk);
        fs_a = 1'b1;
        start_cyc = cyc;
        push_frame(0, 4);
        @(negedge clk);
        fs_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input bit rnd);
        int snap = done_cnt_a;
        int n = 0;
        while (done_cnt_a == snap && n < budget) begin
            @(negedge clk);
            if (rnd) mb_a = ($urandom_range(0, 7) == 0);
            n++;
        end
        mb_a = 1'b0;
        check("frame_completed_in_budget", done_cnt_a - snap, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int wbs;
        fs_a = 1'b0; mb_a = 1'b0; fs_b = 1'b0; mb_b = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk); #3;
        check("reset_busy", int'(busy_a), 0);
        check("reset_wb_en", int'(wb_a), 0);
        check("reset_which", int'(wh_a), 0);
        check("reset_strobes", int'({sl_a, pv_a, us_a, fd_a}), 0);
        check("reset_overrun", int'(ov_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Baseline frame: ready always, update 3 cycles after start.
        wb_cycs_a.delete(); xfer_a = 0; selfpair_a = 0;
        pulse_a(); s = start_cyc;
        wait_done_a(200, 0);
        check("t1_first_load_cycle", load0_cyc_a - s, 1);
        check("t1_wb_count", wb_cycs_a.size(), 4);
        for (int b = 0; b < wb_cycs_a.size() && b < 4; b++)
            check($sformatf("t1_wb_cycle_boid%0d", b), wb_cycs_a[b] - s, (b + 1) * (4 + 3 + 3));
        check("t1_done_cycle", done_cyc_a - s, 4 * (4 + 3 + 3) + 1);
        check("t1_pair_transfers", xfer_a, 4 * 3);
        check("t1_self_transfers", selfpair_a, 0);

        // Three boids: no wrap to index 3, three writebacks.
        begin
            int sb, snap_b, wb0, n;
            wb0 = wb_cnt_b; snap_b = done_cnt_b; n = 0;
            @(negedge clk); fs_b = 1'b1; sb = cyc; push_frame(1, 3);
            @(negedge clk); fs_b = 1'b0;
            while (done_cnt_b == snap_b && n < 200) begin @(negedge clk); n++; end
            check("t5_frame_completed", done_cnt_b - snap_b, 1);
            check("t5_wb_count", wb_cnt_b - wb0, 3);
            check("t5_done_cycle", done_cyc_b - sb, 3 * (3 + 3 + 2) + 1);
        end

        // Five-cycle stall on boid 0's first neighbour.
        first_hold_a = 0; stall_left = 5;
        pulse_a(); s = start_cyc;
        wait_done_a(200, 0);
        check("t2_stall_hold_len", first_hold_a, 6);
        check("t2_done_cycle", done_cyc_a - s, 4 * (4 + 3 + 3) + 1 + 5);

        // Memory busy across the request, dropping 8 cycles later.
        @(negedge clk); mb_a = 1'b1;
        pulse_a(); s = start_cyc;
        #3 check("t3_busy_low_while_mem_busy", int'(busy_a), 0);
        repeat (6) begin
            @(negedge clk); #3;
            check("t3_busy_low_while_mem_busy", int'(busy_a), 0);
        end
        @(negedge clk); mb_a = 1'b0;
        wait_done_a(200, 0);
        check("t3_load_after_drop", load0_cyc_a - s, 9);
        check("t3_done_cycle", done_cyc_a - s, 9 + 4 * (4 + 3 + 3));

        // Memory busy for 4 cycles during PAIR of boid 0.
        pulse_a(); s = start_cyc;
        repeat (2) @(negedge clk);
        mb_a = 1'b1;
        repeat (4) @(negedge clk);
        mb_a = 1'b0;
        wait_done_a(200, 0);
        check("t3b_done_cycle", done_cyc_a - s, 4 * (4 + 3 + 3) + 1 + 4);

        // Second request mid-frame.
        pulse_a(); s = start_cyc;
        repeat (15) @(negedge clk);
        fs_a = 1'b1;
        @(negedge clk); fs_a = 1'b0;
        #3 check("t4_overrun_set", int'(ov_a), 1);
        wait_done_a(200, 0);
        check("t4_done_cycle", done_cyc_a - s, 4 * (4 + 3 + 3) + 1);
        repeat (20) @(negedge clk);
        #3 check("t4_no_second_frame", int'(busy_a), 0);
        check("t4_overrun_sticky", int'(ov_a), 1);

        // Random readiness, update latency and memory-busy bursts.
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            k_a = $urandom_range(1, 5);
            pulse_a();
            wait_done_a(600, 1);
            repeat (2) @(negedge clk);
        end
        ready_mode = 0; k_a = 3;

        // Reset during UPD_WAIT of boid 2.
        wbs = wb_cnt_a;
        pulse_a(); s = start_cyc;
        repeat (27) @(negedge clk);
        rst_n = 1'b0;
        #3 check("t6_async_busy", int'(busy_a), 0);
        @(posedge clk); #1;
        check("t6_edge_busy", int'(busy_a), 0);
        check("t6_edge_wb_en", int'(wb_a), 0);
        check("t6_partial_writebacks", wb_cnt_a - wbs, 2);
        check("t6_overrun_cleared", int'(ov_a), 0);
        qa.delete();
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse_a(); s = start_cyc;
        wait_done_a(200, 0);
        check("t6_restart_load_cycle", load0_cyc_a - s, 1);
        check("t6_restart_done_cycle", done_cyc_a - s, 4 * (4 + 3 + 3) + 1);

        repeat (5) @(negedge clk);
        check("scoreboard_a_drained", qa.size(), 0);
        check("scoreboard_b_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
